// File: rtl/kart_race_engine.sv
// kart_race_engine: frame-sequenced kart physics. One frame_tick walks every
// kart through steer -> trig lookup -> move -> lap check using a shared
// cos/sin table. Optional build macro: KART_COLLISION_EN (rejects a move that
// lands within 64 px of another kart in both axes; zeroes that kart's speed).
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   IDLE      | waiting for frame_tick (ignored once race_over is set)
//   STEER     | update dir/speed of kart k from its steer/accel inputs
//   TRIG_REQ  | one-cycle request of cos/sin for the new heading
//   TRIG_WAIT | hold until trig_valid, latch cos/sin
//   MOVE      | apply velocity, clamp; collision scan when enabled
//   LAPCHK    | count a finish-line crossing, declare a winner
//   NEXT      | advance to the next kart or finish the frame
module kart_race_engine #(
  parameter int NUM_KARTS     = 2,
  parameter int MAX_SPEED     = 6,
  parameter int LAPS_TO_WIN   = 3,
  parameter int POS_MIN       = 64,
  parameter int POS_MAX       = 1984,
  parameter int START_X       = 128,
  parameter int START_SPACING = 128,
  parameter int START_Y       = 100,
  parameter int FINISH_Y      = 100,
  parameter int FINISH_X_LO   = 64,
  parameter int FINISH_X_HI   = 512
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     frame_tick,
  input  logic [NUM_KARTS-1:0]     steer_l,
  input  logic [NUM_KARTS-1:0]     steer_r,
  input  logic [NUM_KARTS-1:0]     accel,
  input  logic                     ext_done,
  output logic                     trig_req,
  output logic [8:0]               trig_angle,
  input  logic                     trig_valid,
  input  logic signed [10:0]       trig_cos,
  input  logic signed [10:0]       trig_sin,
  output logic [11*NUM_KARTS-1:0]  kart_x,
  output logic [11*NUM_KARTS-1:0]  kart_y,
  output logic [9*NUM_KARTS-1:0]   kart_dir,
  output logic [3*NUM_KARTS-1:0]   kart_laps,
  output logic                     busy,
  output logic                     race_over,
  output logic [2:0]               winner,
  output logic                     overrun
);

  typedef enum logic [2:0] {IDLE, STEER, TRIG_REQ, TRIG_WAIT, MOVE, LAPCHK, NEXT} state_t;

  localparam logic [2:0]         LAST_K  = 3'(NUM_KARTS - 1);
  localparam logic [3:0]         SPD_MAX = 4'(MAX_SPEED);
  localparam logic [10:0]        PMIN    = 11'(POS_MIN);
  localparam logic [10:0]        PMAX    = 11'(POS_MAX);
  localparam logic [10:0]        FIN_Y   = 11'(FINISH_Y);
  localparam logic [10:0]        FIN_XL  = 11'(FINISH_X_LO);
  localparam logic [10:0]        FIN_XH  = 11'(FINISH_X_HI);
  localparam logic signed [15:0] PMIN_S  = 16'(POS_MIN);
  localparam logic signed [15:0] PMAX_S  = 16'(POS_MAX);

  state_t state;
  logic [2:0] k;

  // Per-kart state is held in 8-entry arrays so the 3-bit index always fits;
  // entries at or above NUM_KARTS are never visited.
  logic [10:0] x_r    [8];
  logic [10:0] y_r    [8];
  logic [8:0]  dir_r  [8];
  logic [3:0]  spd_r  [8];
  logic [2:0]  laps_r [8];

  logic signed [10:0] cos_r, sin_r;
  logic [10:0]        prev_y;

  logic [7:0] sl_ext, sr_ext, ac_ext;
  assign sl_ext = 8'(steer_l);
  assign sr_ext = 8'(steer_r);
  assign ac_ext = 8'(accel);

  // Next heading and speed for the kart being steered.
  logic [8:0] dir_nxt;
  logic [3:0] spd_nxt;
  always_comb begin
    dir_nxt = dir_r[k];
    if (sl_ext[k] && !sr_ext[k])
      dir_nxt = (dir_r[k] == 9'd359) ? 9'd0 : dir_r[k] + 9'd1;
    else if (sr_ext[k] && !sl_ext[k])
      dir_nxt = (dir_r[k] == 9'd0) ? 9'd359 : dir_r[k] - 9'd1;
    spd_nxt = spd_r[k];
    if (ac_ext[k])
      spd_nxt = (spd_r[k] >= SPD_MAX) ? SPD_MAX : spd_r[k] + 4'd1;
    else if (spd_r[k] != 4'd0)
      spd_nxt = spd_r[k] - 4'd1;
  end

  // Velocity in signed 16-bit, screen y grows downward so sin is negated.
  logic signed [15:0] spd_s, cos_s, sin_s, prod_x, prod_y, dx, dy, sum_x, sum_y;
  logic [10:0]        cand_x, cand_y;
  always_comb begin
    spd_s  = $signed({12'd0, spd_r[k]});
    cos_s  = $signed({{5{cos_r[10]}}, cos_r});
    sin_s  = $signed({{5{sin_r[10]}}, sin_r});
    prod_x = spd_s * cos_s;
    prod_y = spd_s * sin_s;
    dx     = prod_x >>> 9;
    dy     = -(prod_y >>> 9);
    sum_x  = $signed({5'd0, x_r[k]}) + dx;
    sum_y  = $signed({5'd0, y_r[k]}) + dy;
    if (sum_x < PMIN_S)      cand_x = PMIN;
    else if (sum_x > PMAX_S) cand_x = PMAX;
    else                     cand_x = sum_x[10:0];
    if (sum_y < PMIN_S)      cand_y = PMIN;
    else if (sum_y > PMAX_S) cand_y = PMAX;
    else                     cand_y = sum_y[10:0];
  end

  // Finish-line crossing: from below the line (larger y) onto or past it.
  logic       lap_hit;
  logic [2:0] lap_nxt;
  always_comb begin
    lap_hit = (prev_y > FIN_Y) && (y_r[k] <= FIN_Y) &&
              (x_r[k] >= FIN_XL) && (x_r[k] <= FIN_XH);
    lap_nxt = (laps_r[k] == 3'd7) ? 3'd7 : laps_r[k] + 3'd1;
  end

`ifdef KART_COLLISION_EN
  logic [2:0] j_r;
  logic       hit_r, hit_j;

  function automatic logic [10:0] absd(input logic [10:0] a, input logic [10:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  // Overlap test of kart k's candidate against kart j_r (self excluded).
  always_comb begin
    hit_j = (j_r != k) && (int'(j_r) < NUM_KARTS) &&
            (absd(cand_x, x_r[j_r]) < 11'd64) && (absd(cand_y, y_r[j_r]) < 11'd64);
  end
`endif

  // Frame sequencer, per-kart state and race status.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      k          <= '0;
      busy       <= 1'b0;
      race_over  <= 1'b0;
      winner     <= '0;
      overrun    <= 1'b0;
      trig_req   <= 1'b0;
      trig_angle <= '0;
      cos_r      <= '0;
      sin_r      <= '0;
      prev_y     <= '0;
`ifdef KART_COLLISION_EN
      j_r        <= '0;
      hit_r      <= 1'b0;
`endif
      for (int i = 0; i < 8; i++) begin
        x_r[i]    <= 11'(START_X + i * START_SPACING);
        y_r[i]    <= 11'(START_Y);
        dir_r[i]  <= '0;
        spd_r[i]  <= '0;
        laps_r[i] <= '0;
      end
    end else begin
      if (frame_tick && busy)
        overrun <= 1'b1;
      if (ext_done && !race_over) begin
        race_over <= 1'b1;
        winner    <= 3'd7;
      end
      case (state)
        IDLE: begin
          if (frame_tick && !race_over) begin
            k     <= '0;
            busy  <= 1'b1;
            state <= STEER;
          end
        end
        STEER: begin
          dir_r[k]   <= dir_nxt;
          spd_r[k]   <= spd_nxt;
          trig_angle <= dir_nxt;
          trig_req   <= 1'b1;
          state      <= TRIG_REQ;
        end
        TRIG_REQ: begin
          trig_req <= 1'b0;
          state    <= TRIG_WAIT;
        end
        TRIG_WAIT: begin
          if (trig_valid) begin
            cos_r <= trig_cos;
            sin_r <= trig_sin;
`ifdef KART_COLLISION_EN
            j_r   <= '0;
            hit_r <= 1'b0;
`endif
            state <= MOVE;
          end
        end
        MOVE: begin
`ifdef KART_COLLISION_EN
          if (j_r == LAST_K) begin
            prev_y <= y_r[k];
            if (hit_r || hit_j) begin
              spd_r[k] <= '0;
            end else begin
              x_r[k] <= cand_x;
              y_r[k] <= cand_y;
            end
            state <= LAPCHK;
          end else begin
            j_r   <= j_r + 3'd1;
            hit_r <= hit_r | hit_j;
          end
`else
          prev_y <= y_r[k];
          x_r[k] <= cand_x;
          y_r[k] <= cand_y;
          state  <= LAPCHK;
`endif
        end
        LAPCHK: begin
          if (lap_hit) begin
            laps_r[k] <= lap_nxt;
            if (!race_over && int'(lap_nxt) >= LAPS_TO_WIN) begin
              race_over <= 1'b1;
              winner    <= k;
            end
          end
          state <= NEXT;
        end
        NEXT: begin
          if (k != LAST_K) begin
            k     <= k + 3'd1;
            state <= STEER;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Pack the per-kart registers onto the output buses, kart 0 in the LSBs.
  always_comb begin
    kart_x    = '0;
    kart_y    = '0;
    kart_dir  = '0;
    kart_laps = '0;
    for (int i = 0; i < NUM_KARTS; i++) begin
      kart_x[11*i +: 11]  = x_r[i];
      kart_y[11*i +: 11]  = y_r[i];
      kart_dir[9*i +: 9]  = dir_r[i];
      kart_laps[3*i +: 3] = laps_r[i];
    end
  end

endmodule
